// File: rtl/lru_state_tracker_if.sv
// rtl/lru_state_tracker_if.sv - update/query/flush bundle for the LRU state tracker
//
// Signals:
//   upd_valid/upd_ready   update handshake, accepted when both high at an edge
//   upd_op                00 hit, 01 fill, 10 invalidate, 11 reserved
//   upd_index/upd_way     target set and way of the update
//   upd_err               one-cycle pulse after a hit/invalidate on an invalid way
//   q_index               query set, sampled every edge
//   q_victim_way          victim way of the set sampled on the previous edge
//   q_valid_mask          valid bits of that set (bit i = way i)
//   flush_req/flush_busy  start a clearing sweep / sweep in progress
// Modports: master drives requests, slave is the tracker.
interface lru_state_tracker_if #(
  parameter int INDEX_BITS = 8,
  parameter int WAYS       = 4,
  parameter int WAY_BITS   = 2
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic [1:0]            upd_op;
  logic [INDEX_BITS-1:0] upd_index;
  logic [WAY_BITS-1:0]   upd_way;
  logic                  upd_err;
  logic [INDEX_BITS-1:0] q_index;
  logic [WAY_BITS-1:0]   q_victim_way;
  logic [WAYS-1:0]       q_valid_mask;
  logic                  flush_req;
  logic                  flush_busy;

  modport master (
    output upd_valid, upd_op, upd_index, upd_way, q_index, flush_req,
    input  upd_ready, upd_err, q_victim_way, q_valid_mask, flush_busy
  );

  modport slave (
    input  upd_valid, upd_op, upd_index, upd_way, q_index, flush_req,
    output upd_ready, upd_err, q_victim_way, q_valid_mask, flush_busy
  );
endinterface

// File: rtl/lru_state_tracker.sv
// rtl/lru_state_tracker.sv - per-set valid/age replacement state with victim query and clearing sweep
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset; restarts the clearing sweep at set 0
//   bus   lru_state_tracker_if.slave (update handshake, query, flush)
module lru_state_tracker #(
  parameter int CACHE_LINES = 256,
  parameter int INDEX_BITS  = 8,
  parameter int WAYS        = 4,
  parameter int WAY_BITS    = 2
) (
  input logic                clk,
  input logic                rst,
  lru_state_tracker_if.slave bus
);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t                        r_state;
  logic [INDEX_BITS-1:0]         r_sweep_cnt;
  logic [WAYS-1:0]               r_valid [CACHE_LINES];
  logic [WAYS-1:0][WAY_BITS-1:0] r_age   [CACHE_LINES];
  logic                          r_upd_err;
  logic [WAY_BITS-1:0]           r_victim;
  logic [WAYS-1:0]               r_mask;

  logic                          w_ready;
  logic                          w_accept;
  logic [WAYS-1:0]               w_cur_valid;
  logic [WAYS-1:0][WAY_BITS-1:0] w_cur_age;
  logic                          w_tgt_valid;
  logic [WAY_BITS-1:0]           w_tgt_age;
  logic [WAYS-1:0]               w_nxt_valid;
  logic [WAYS-1:0][WAY_BITS-1:0] w_nxt_age;
  logic                          w_err;
  logic [WAYS-1:0]               w_q_valid;
  logic [WAYS-1:0][WAY_BITS-1:0] w_q_age;
  logic [WAY_BITS-1:0]           w_victim;

  // rst is folded in so the handshake stays closed while reset is held.
  assign w_ready  = (r_state == IDLE) && !bus.flush_req && !rst;
  assign w_accept = bus.upd_valid && w_ready;

  assign bus.upd_ready    = w_ready;
  assign bus.upd_err      = r_upd_err;
  assign bus.q_victim_way = r_victim;
  assign bus.q_valid_mask = r_mask;
  assign bus.flush_busy   = (r_state == SWEEP);

  // Next state of the targeted set. Ages stay a permutation of 0..k-1
  // over the valid ways.
  assign w_cur_valid = r_valid[bus.upd_index];
  assign w_cur_age   = r_age[bus.upd_index];
  assign w_tgt_valid = w_cur_valid[bus.upd_way];
  assign w_tgt_age   = w_cur_age[bus.upd_way];

  always_comb begin
    w_nxt_valid = w_cur_valid;
    w_nxt_age   = w_cur_age;
    w_err       = 1'b0;
    case (bus.upd_op)
      2'b00, 2'b01: begin
        if (w_tgt_valid) begin
          // Hit, or fill of an already-valid way: promote to MRU.
          for (int i = 0; i < WAYS; i++) begin
            if (w_cur_valid[i] && (w_cur_age[i] < w_tgt_age))
              w_nxt_age[i] = w_cur_age[i] + WAY_BITS'(1);
          end
          w_nxt_age[bus.upd_way] = '0;
        end else if (bus.upd_op == 2'b01) begin
          for (int i = 0; i < WAYS; i++) begin
            if (w_cur_valid[i])
              w_nxt_age[i] = w_cur_age[i] + WAY_BITS'(1);
          end
          w_nxt_valid[bus.upd_way] = 1'b1;
          w_nxt_age[bus.upd_way]   = '0;
        end else begin
          w_err = 1'b1;
        end
      end
      2'b10: begin
        if (w_tgt_valid) begin
          // Close the gap left by the removed rank.
          for (int i = 0; i < WAYS; i++) begin
            if (w_cur_valid[i] && (w_cur_age[i] > w_tgt_age))
              w_nxt_age[i] = w_cur_age[i] - WAY_BITS'(1);
          end
          w_nxt_valid[bus.upd_way] = 1'b0;
        end else begin
          w_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Victim: lowest-numbered invalid way, else the way holding the oldest rank.
  assign w_q_valid = r_valid[bus.q_index];
  assign w_q_age   = r_age[bus.q_index];

  always_comb begin
    w_victim = '0;
    if (&w_q_valid) begin
      for (int i = 0; i < WAYS; i++) begin
        if (w_q_age[i] == WAY_BITS'(WAYS - 1))
          w_victim = WAY_BITS'(i);
      end
    end else begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (!w_q_valid[i])
          w_victim = WAY_BITS'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SWEEP;
      r_sweep_cnt <= '0;
      r_upd_err   <= 1'b0;
      r_victim    <= '0;
      r_mask      <= '0;
    end else begin
      r_upd_err <= w_accept && w_err;
      if (r_state == SWEEP) begin
        r_victim <= '0;
        r_mask   <= '0;
      end else begin
        r_victim <= w_victim;
        r_mask   <= w_q_valid;
      end
      case (r_state)
        SWEEP: begin
          r_sweep_cnt <= r_sweep_cnt + INDEX_BITS'(1);
          if (r_sweep_cnt == INDEX_BITS'(CACHE_LINES - 1))
            r_state <= IDLE;
        end
        IDLE: begin
          if (bus.flush_req) begin
            r_state     <= SWEEP;
            r_sweep_cnt <= '0;
          end
        end
        default: r_state <= SWEEP;
      endcase
    end
  end

  // Replacement storage is not reset directly; the sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == SWEEP) begin
        r_valid[r_sweep_cnt] <= '0;
        r_age[r_sweep_cnt]   <= '0;
      end else if (w_accept) begin
        r_valid[bus.upd_index] <= w_nxt_valid;
        r_age[bus.upd_index]   <= w_nxt_age;
      end
    end
  end

endmodule
